// File: rtl/demux_1x4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x4_tdm
// Brief    : Frame-locked 1-to-4 TDM demultiplexer with sync hunting and
//            atomic update of the four channel outputs.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1x4_tdm #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         sync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         frame_valid,
    output logic         sync_err,
    output logic         locked
);

    localparam logic [0:0] c_HUNT   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [1:0]         r_slot;
    logic [1:0]         w_slot_nxt;
    logic [2:0][W-1:0]  r_shadow;
    logic [2:0][W-1:0]  w_shadow_nxt;
    logic               w_load;
    logic               w_err;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_c;
    logic [W-1:0]       r_d;
    logic               r_frame_valid;
    logic               r_sync_err;
    logic               r_locked;

    // Any beat carrying sync restarts a frame at slot 0; only off-slot syncs are errors.
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_shadow_nxt = r_shadow;
        w_load       = 1'b0;
        w_err        = 1'b0;
        if (din_valid) begin
            case (r_state)
                c_HUNT: begin
                    if (sync) begin
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 2'd1;
                        w_state_nxt     = c_LOCKED;
                    end
                end
                default: begin
                    if (sync) begin
                        w_err           = (r_slot != 2'd0);
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 2'd1;
                    end else if (r_slot == 2'd0) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_HUNT;
                    end else if (r_slot == 2'd3) begin
                        w_load     = 1'b1;
                        w_slot_nxt = 2'd0;
                    end else begin
                        if (r_slot == 2'd1) begin
                            w_shadow_nxt[1] = din;
                        end else begin
                            w_shadow_nxt[2] = din;
                        end
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_HUNT;
            r_slot        <= 2'd0;
            r_shadow      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_shadow      <= w_shadow_nxt;
            r_frame_valid <= w_load;
            r_sync_err    <= w_err;
            r_locked      <= (w_state_nxt == c_LOCKED);
            if (w_load) begin
                r_a <= r_shadow[0];
                r_b <= r_shadow[1];
                r_c <= r_shadow[2];
                r_d <= din;
            end
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign c           = r_c;
    assign d           = r_d;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1x4_tdm
// Brief    : Scoreboard bench for demux_1x4_tdm against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x4_tdm;

    localparam int W = 1;

    typedef struct {
        bit             is_err;
        logic [4*W-1:0] data;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         sync;
    logic [W-1:0] a, b, c, d;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;

    demux_1x4_tdm #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .a(a), .b(b), .c(c), .d(d),
        .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int fv_cyc[$];

    // Reference model: samples of the frame being collected, plus lock flag.
    logic [W-1:0]   mq[$];
    bit             m_locked   = 1'b0;
    logic [4*W-1:0] exp_out    = '0;
    logic           exp_locked = 1'b0;
    ev_t            exp_q[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push_ev(input bit is_err, input logic [4*W-1:0] data);
        ev_t e;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic model_beat(input logic s, input logic [W-1:0] dv);
        if (!m_locked) begin
            if (s) begin
                mq = {dv};
                m_locked = 1'b1;
            end
        end else if (s) begin
            if (mq.size() != 0) push_ev(1'b1, '0);
            mq = {dv};
        end else if (mq.size() == 0) begin
            push_ev(1'b1, '0);
            m_locked = 1'b0;
        end else begin
            mq.push_back(dv);
            if (mq.size() == 4) begin
                exp_out = {mq[0], mq[1], mq[2], mq[3]};
                push_ev(1'b0, exp_out);
                mq.delete();
            end
        end
        exp_locked = m_locked;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_locked   = 1'b0;
        exp_locked = 1'b0;
        exp_out    = '0;
    endtask

    task automatic beat(input logic v, input logic s, input logic [W-1:0] dv);
        @(negedge clk);
        din_valid = v;
        sync      = s;
        din       = dv;
        if (v) model_beat(s, dv);
    endtask

    task automatic send_frame(input logic [3:0] p);
        beat(1'b1, 1'b1, W'(p[3]));
        beat(1'b1, 1'b0, W'(p[2]));
        beat(1'b1, 1'b0, W'(p[1]));
        beat(1'b1, 1'b0, W'(p[0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, '0);
    endtask

    // Monitor: one expected event per cycle at most, consumed when the DUT presents it.
    always @(posedge clk) begin : mon
        ev_t e;
        #1;
        cyc = cyc + 1;
        chk(!(frame_valid && sync_err), "pulse_exclusive", 32'({frame_valid, sync_err}), 32'd0);
        chk(locked == exp_locked, "locked", 32'(locked), 32'(exp_locked));
        chk({a, b, c, d} == exp_out, "outputs", 32'({a, b, c, d}), 32'(exp_out));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_err)
                chk(sync_err && !frame_valid, "sync_err_pulse", 32'({frame_valid, sync_err}), 32'd1);
            else
                chk(frame_valid && !sync_err && ({a, b, c, d} == e.data), "frame_pulse",
                    32'({frame_valid, sync_err, a, b, c, d}), 32'({2'b10, e.data}));
        end else begin
            chk(!frame_valid && !sync_err, "no_pulse", 32'({frame_valid, sync_err}), 32'd0);
        end
        if (frame_valid) fv_cyc.push_back(cyc);
    end

    initial begin
        int fails_before;
        int pos;
        logic v, s;
        rst_n     = 1'b1;
        din_valid = 1'b0;
        sync      = 1'b0;
        din       = '0;
        #2 rst_n = 1'b0;
        #1;
        chk({a, b, c, d, frame_valid, sync_err, locked} == '0, "async_reset",
            32'({a, b, c, d, frame_valid, sync_err, locked}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic frame 1,0,1,1
        send_frame(4'b1011);
        idle(3);

        // Exhaustive back-to-back sweep
        fv_cyc.delete();
        fails_before = n_total - n_pass;
        for (int p = 0; p < 16; p++) send_frame(4'(p));
        idle(2);
        chk(fv_cyc.size() == 16, "sweep_pulse_count", 32'(fv_cyc.size()), 32'd16);
        for (int i = 1; i < fv_cyc.size(); i++)
            chk(fv_cyc[i] - fv_cyc[i-1] == 4, "sweep_spacing", 32'(fv_cyc[i] - fv_cyc[i-1]), 32'd4);
        if (n_total - n_pass == fails_before) $display("exhaustive 16-pattern sweep PASS");

        // Valid gap between beats 2 and 3
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        idle(3);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        idle(2);

        // Early sync on slot 2, then the resync frame completes
        send_frame(4'b0110);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        idle(2);

        // Missing sync at slot 0 drops lock; further non-sync beats are silent
        beat(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, W'(i));
        idle(2);
        send_frame(4'b1001);
        idle(2);

        // Asynchronous reset between edges after the slot-1 beat
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk({a, b, c, d, frame_valid, sync_err, locked} == '0, "midframe_reset",
            32'({a, b, c, d, frame_valid, sync_err, locked}), 32'd0);
        beat(1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        fv_cyc.delete();
        send_frame(4'b1101);
        idle(3);
        chk(fv_cyc.size() == 1, "post_reset_frames", 32'(fv_cyc.size()), 32'd1);

        // Randomized traffic with mostly well-formed framing
        pos = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 8);
            s = (pos == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
            beat(v, s, W'($urandom));
            if (v) pos = s ? 1 : (pos + 1) % 4;
        end
        idle(3);
        chk(exp_q.size() == 0, "scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
